// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline register.
// The state encoding doubles as the occupancy count.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

endpackage

// File: rtl/skid_data_reg.sv
// Enable-controlled data entry, used for both the main and the skid slot.
// The asynchronous active-low reset clears it to zero.
module skid_data_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture only when the owner asserts the enable; otherwise hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= {WIDTH{1'b0}};
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register. in_ready depends only on state and
// flush, so a downstream stall never reaches upstream combinationally.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   skid_state_t      state_r;
   skid_state_t      state_nxt_s;
   logic             in_fire_s;
   logic             out_fire_s;
   logic             main_en_s;
   logic             skid_en_s;
   logic [WIDTH-1:0] main_d_s;
   logic [WIDTH-1:0] main_q_s;
   logic [WIDTH-1:0] skid_q_s;

   assign in_ready   = (state_r != FULL) & ~flush;
   assign out_valid  = (state_r != EMPTY);
   assign out_data   = main_q_s;
   assign count      = state_r;
   assign in_fire_s  = in_valid & in_ready;
   assign out_fire_s = out_valid & out_ready;

   // When FULL the only way main is written is by promoting the skid word.
   assign main_d_s = (state_r == FULL) ? skid_q_s : in_data;

   // Next-state and entry-enable decode; flush overrides every transition.
   always_comb begin
      state_nxt_s = state_r;
      main_en_s   = 1'b0;
      skid_en_s   = 1'b0;
      if (flush) begin
         state_nxt_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (in_fire_s) begin
                  main_en_s   = 1'b1;
                  state_nxt_s = ONE;
               end else begin
                  state_nxt_s = EMPTY;
               end
            end
            ONE: begin
               if (in_fire_s && out_fire_s) begin
                  main_en_s   = 1'b1;
                  state_nxt_s = ONE;
               end else if (in_fire_s) begin
                  skid_en_s   = 1'b1;
                  state_nxt_s = FULL;
               end else if (out_fire_s) begin
                  state_nxt_s = EMPTY;
               end else begin
                  state_nxt_s = ONE;
               end
            end
            FULL: begin
               if (out_fire_s) begin
                  main_en_s   = 1'b1;
                  state_nxt_s = ONE;
               end else begin
                  state_nxt_s = FULL;
               end
            end
            default: begin
               state_nxt_s = EMPTY;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   skid_data_reg #(.WIDTH(WIDTH)) u_main (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (main_en_s),
      .d       (main_d_s),
      .q       (main_q_s)
   );

   skid_data_reg #(.WIDTH(WIDTH)) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (skid_en_s),
      .d       (in_data),
      .q       (skid_q_s)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table and hand sequences on WIDTH=8,
// then a randomized queue-model scoreboard on WIDTH=1, 8 and 32 in parallel.
module tb_pipe_skid_reg;

   typedef struct {
      logic       fl;
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       ir;
      logic       ov;
      logic [7:0] od;
      logic [1:0] cnt;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic        fl   [3];
   logic        iv   [3];
   logic        ordy [3];
   logic        ir   [3];
   logic        ov   [3];
   logic [1:0]  cnt  [3];
   logic [31:0] id_a [3];
   logic [31:0] od_a [3];
   logic [31:0] mask [3];
   logic [0:0]  od_w1;
   logic [7:0]  od_w8;
   logic [31:0] od_w32;
   logic [31:0] mq   [3][$];
   vec_t        vec  [16];
   int          n_cmp;
   int          n_fail;

   assign od_a[0] = {31'd0, od_w1};
   assign od_a[1] = {24'd0, od_w8};
   assign od_a[2] = od_w32;

   pipe_skid_reg #(.WIDTH(1)) dut_w1 (
      .clk(clk), .reset_n(reset_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_data(id_a[0][0:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od_w1),
      .count(cnt[0]));

   pipe_skid_reg #(.WIDTH(8)) dut_w8 (
      .clk(clk), .reset_n(reset_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_data(id_a[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od_w8),
      .count(cnt[1]));

   pipe_skid_reg #(.WIDTH(32)) dut_w32 (
      .clk(clk), .reset_n(reset_n), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
      .in_data(id_a[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od_w32),
      .count(cnt[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic idle_all();
      for (int i = 0; i < 3; i++) begin
         fl[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0; id_a[i] = 32'd0;
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      mask[0] = 32'h0000_0001;
      mask[1] = 32'h0000_00FF;
      mask[2] = 32'hFFFF_FFFF;

      //             fl    iv    d      ordy  ir    ov    od     cnt
      vec[0]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
      vec[1]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd1};
      vec[2]  = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2};
      vec[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2};
      vec[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd2};
      vec[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 2'd1};
      vec[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
      vec[7]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
      vec[8]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1};
      vec[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 2'd1};
      vec[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1};
      vec[11] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
      vec[12] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h33, 2'd1};
      vec[13] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h33, 2'd2};
      vec[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
      vec[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};

      idle_all();
      reset_n = 1'b0;
      #12;
      chk("rst_count", {30'd0, cnt[1]}, 32'd0);
      chk("rst_out_valid", {31'd0, ov[1]}, 32'd0);
      chk("rst_out_data", od_a[1], 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst_in_ready", {31'd0, ir[1]}, 32'd1);
      @(posedge clk); #1;

      // Reset while FULL
      iv[1] = 1'b1; id_a[1] = 32'hC3;
      @(posedge clk); #1;
      id_a[1] = 32'h3C;
      @(posedge clk); #1;
      iv[1] = 1'b0;
      @(negedge clk);
      chk("mid_full_count", {30'd0, cnt[1]}, 32'd2);
      chk("mid_full_in_ready", {31'd0, ir[1]}, 32'd0);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_count", {30'd0, cnt[1]}, 32'd0);
      chk("mid_rst_out_valid", {31'd0, ov[1]}, 32'd0);
      chk("mid_rst_out_data", od_a[1], 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("mid_rst_in_ready", {31'd0, ir[1]}, 32'd1);
      @(posedge clk); #1;

      // Streaming 0x01..0x10 with out_ready high
      ordy[1] = 1'b1;
      for (int k = 0; k < 18; k++) begin
         iv[1]   = (k < 16);
         id_a[1] = 32'(k + 1);
         @(negedge clk);
         if (k == 0) begin
            chk("stream_count0", {30'd0, cnt[1]}, 32'd0);
         end else if (k <= 16) begin
            chk("stream_data", od_a[1], 32'(k));
            chk("stream_count", {30'd0, cnt[1]}, 32'd1);
            chk("stream_in_ready", {31'd0, ir[1]}, 32'd1);
         end else begin
            chk("stream_drained", {30'd0, cnt[1]}, 32'd0);
         end
         @(posedge clk); #1;
      end
      idle_all();

      // Vector table: backpressure, simultaneous fire, flush
      for (int r = 0; r < 16; r++) begin
         fl[1] = vec[r].fl; iv[1] = vec[r].iv; id_a[1] = {24'd0, vec[r].d}; ordy[1] = vec[r].ordy;
         @(negedge clk);
         chk($sformatf("vec%0d_in_ready", r), {31'd0, ir[1]}, {31'd0, vec[r].ir});
         chk($sformatf("vec%0d_out_valid", r), {31'd0, ov[1]}, {31'd0, vec[r].ov});
         chk($sformatf("vec%0d_count", r), {30'd0, cnt[1]}, {30'd0, vec[r].cnt});
         if (vec[r].ov) chk($sformatf("vec%0d_out_data", r), od_a[1], {24'd0, vec[r].od});
         @(posedge clk); #1;
      end
      idle_all();

      // Randomized scoreboard across all widths
      reset_n = 1'b0;
      #3;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) mq[i].delete();
      @(posedge clk); #1;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 3; i++) begin
            fl[i]   = ($urandom_range(0, 40) == 0);
            iv[i]   = ($urandom_range(0, 3) != 0);
            ordy[i] = (c[9]) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            id_a[i] = $urandom();
         end
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            automatic int sz;
            sz = mq[i].size();
            chk($sformatf("rnd%0d_count", i), {30'd0, cnt[i]}, 32'(sz));
            chk($sformatf("rnd%0d_in_ready", i), {31'd0, ir[i]}, {31'd0, (sz < 2) && !fl[i]});
            chk($sformatf("rnd%0d_out_valid", i), {31'd0, ov[i]}, {31'd0, sz > 0});
            if (sz > 0) chk($sformatf("rnd%0d_out_data", i), od_a[i], mq[i][0]);
            if (fl[i]) begin
               mq[i].delete();
            end else begin
               if (sz > 0 && ordy[i]) void'(mq[i].pop_front());
               if (sz < 2 && iv[i]) mq[i].push_back(id_a[i] & mask[i]);
            end
         end
         @(posedge clk); #1;
      end
      idle_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
